// File: rtl/fetch_decode_latch.sv
// IF/ID pipeline register: captures fetch outputs, holds on stall, inserts NOP
// bubbles after a taken branch and freezes the front end once HALT reaches decode.
module fetch_decode_latch #(
    parameter logic [15:0] NOP_INSTR     = 16'h0800,
    parameter int          SQUASH_CYCLES = 2,
    parameter logic [4:0]  HALT_OPCODE   = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instrF,
    input  logic [15:0] incPCF,
    input  logic        errF,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] instrD,
    output logic [15:0] incPCD,
    output logic        validD,
    output logic        errD,
    output logic        pcWrEn,
    output logic        halted,
    output logic        squashing
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [2:0] SQ_RELOAD = 3'(SQUASH_CYCLES - 1);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [15:0] r_instr;
    logic [15:0] r_incpc;
    logic        r_valid;
    logic        r_err;

    state_t      w_state_nx;
    logic [2:0]  w_cnt_nx;
    logic [15:0] w_instr_nx;
    logic [15:0] w_incpc_nx;
    logic        w_valid_nx;
    logic        w_err_nx;
    logic        w_is_halt;

    assign w_is_halt = (instrF[15:11] == HALT_OPCODE) && !errF;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_instr_nx = r_instr;
        w_incpc_nx = r_incpc;
        w_valid_nx = r_valid;
        w_err_nx   = r_err;

        // Flush has the same effect in every state; it also clears a wrong-path halt.
        if (flush) begin
            w_instr_nx = NOP_INSTR;
            w_valid_nx = 1'b0;
            w_err_nx   = 1'b0;
            if (SQUASH_CYCLES > 1) begin
                w_state_nx = SQUASH;
                w_cnt_nx   = SQ_RELOAD;
            end else begin
                w_state_nx = RUN;
                w_cnt_nx   = 3'd0;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (!stall) begin
                        w_instr_nx = instrF;
                        w_incpc_nx = incPCF;
                        w_valid_nx = 1'b1;
                        w_err_nx   = errF;
                        if (w_is_halt) w_state_nx = HALTED;
                    end
                end
                SQUASH: begin
                    w_instr_nx = NOP_INSTR;
                    w_valid_nx = 1'b0;
                    w_err_nx   = 1'b0;
                    w_cnt_nx   = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_state_nx = RUN;
                        w_cnt_nx   = 3'd0;
                    end
                end
                HALTED: begin
                    if (!stall) begin
                        w_instr_nx = NOP_INSTR;
                        w_valid_nx = 1'b0;
                        w_err_nx   = 1'b0;
                    end
                end
                default: begin
                    w_state_nx = RUN;
                    w_cnt_nx   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
            r_instr <= NOP_INSTR;
            r_incpc <= 16'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_instr <= w_instr_nx;
            r_incpc <= w_incpc_nx;
            r_valid <= w_valid_nx;
            r_err   <= w_err_nx;
        end
    end

    assign pcWrEn = flush || !((r_state == HALTED) || ((r_state == RUN) && stall));

    assign instrD    = r_instr;
    assign incPCD    = r_incpc;
    assign validD    = r_valid;
    assign errD      = r_err & r_valid;
    assign halted    = (r_state == HALTED);
    assign squashing = (r_state == SQUASH);

endmodule

// File: tb/tb_fetch_decode_latch.sv
// Directed and randomized checks of fetch_decode_latch against a behavioural model.
module tb_fetch_decode_latch;

    logic        clk = 1'b0;
    logic        rst, errF, stall, flush;
    logic [15:0] instrF, incPCF;
    logic [15:0] instrD, incPCD;
    logic        validD, errD, pcWrEn, halted, squashing;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: decode view plus "bubbles still owed" and a halt flag.
    logic [15:0] m_instr, m_pc;
    logic        m_valid, m_err, m_halted;
    int          m_bubbles;

    localparam logic [15:0] NOP = 16'h0800;
    localparam int          SQ  = 2;

    fetch_decode_latch dut (
        .clk(clk), .rst(rst), .instrF(instrF), .incPCF(incPCF), .errF(errF),
        .stall(stall), .flush(flush), .instrD(instrD), .incPCD(incPCD),
        .validD(validD), .errD(errD), .pcWrEn(pcWrEn), .halted(halted),
        .squashing(squashing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_pcwr(input logic s, input logic f);
        if (f) return 1'b1;
        if (m_halted) return 1'b0;
        if (m_bubbles == 0 && s) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input logic r, input logic [15:0] i, input logic [15:0] p,
                              input logic e, input logic s, input logic f);
        if (!r) begin
            m_instr = NOP; m_pc = 16'd0; m_valid = 0; m_err = 0;
            m_bubbles = 0; m_halted = 0;
        end else if (f) begin
            m_instr = NOP; m_valid = 0; m_err = 0;
            m_bubbles = SQ - 1; m_halted = 0;
        end else if (m_bubbles > 0) begin
            m_instr = NOP; m_valid = 0; m_err = 0;
            m_bubbles--;
        end else if (s) begin
            // everything holds
        end else if (m_halted) begin
            m_instr = NOP; m_valid = 0; m_err = 0;
        end else begin
            m_instr = i; m_pc = p; m_valid = 1; m_err = e;
            if (i[15:11] == 5'b00000 && !e) m_halted = 1;
        end
    endtask

    task automatic cyc(input logic r, input logic [15:0] i, input logic [15:0] p,
                       input logic e, input logic s, input logic f, input bit chk_pc = 1);
        rst = r; instrF = i; incPCF = p; errF = e; stall = s; flush = f;
        #1;
        if (chk_pc) chk("pcWrEn", 16'(pcWrEn), 16'(model_pcwr(s, f)));
        @(posedge clk);
        model_edge(r, i, p, e, s, f);
        #1;
        chk("instrD", instrD, m_instr);
        chk("incPCD", incPCD, m_pc);
        chk("validD", 16'(validD), 16'(m_valid));
        chk("errD", 16'(errD), 16'(m_err & m_valid));
        chk("halted", 16'(halted), 16'(m_halted));
        chk("squashing", 16'(squashing), 16'(m_bubbles > 0));
    endtask

    initial begin
        m_instr = NOP; m_pc = 0; m_valid = 0; m_err = 0; m_bubbles = 0; m_halted = 0;
        rst = 0; instrF = 0; incPCF = 0; errF = 0; stall = 0; flush = 0;
        @(posedge clk); #1;

        // reset and first load
        cyc(0, 16'h1111, 16'h2222, 0, 0, 0, 0);
        cyc(0, 16'h1111, 16'h2222, 0, 0, 0);
        chk("rst_instrD", instrD, 16'h0800);
        cyc(1, 16'h4123, 16'h0002, 0, 0, 0);
        chk("load_instrD", instrD, 16'h4123);

        // stall hold then release
        for (int k = 0; k < 3; k++) cyc(1, 16'hC5AA, 16'h0004, 0, 1, 0);
        chk("stall_hold", instrD, 16'h4123);
        cyc(1, 16'hC5AA, 16'h0004, 0, 0, 0);
        chk("stall_release", instrD, 16'hC5AA);

        // single flush: two bubbles then load
        cyc(1, 16'h5000, 16'h0006, 0, 0, 1);
        cyc(1, 16'h5001, 16'h0008, 0, 0, 0);
        chk("bubble2", instrD, 16'h0800);
        cyc(1, 16'h5002, 16'h000A, 0, 0, 0);
        chk("after_window", instrD, 16'h5002);

        // re-flush in second bubble extends window to three
        cyc(1, 16'h6000, 16'h000C, 0, 0, 1);
        cyc(1, 16'h6001, 16'h000E, 0, 0, 1);
        cyc(1, 16'h6002, 16'h0010, 0, 0, 0);
        chk("bubble3", instrD, 16'h0800);
        cyc(1, 16'h6003, 16'h0012, 0, 0, 0);

        // flush beats stall
        cyc(1, 16'h7000, 16'h0014, 0, 1, 1);
        cyc(1, 16'h7001, 16'h0016, 0, 1, 0);
        cyc(1, 16'h7002, 16'h0018, 0, 0, 0);

        // HALT capture, NOP afterwards, stall in HALTED, flush out
        cyc(1, 16'h0000, 16'h001A, 0, 0, 0);
        chk("halt_instrD", instrD, 16'h0000);
        cyc(1, 16'h8000, 16'h001C, 0, 0, 0);
        cyc(1, 16'h8001, 16'h001E, 0, 1, 0);
        cyc(1, 16'h8002, 16'h0020, 0, 0, 0);
        cyc(1, 16'h8003, 16'h0022, 0, 0, 1);
        chk("halt_flushed", 16'(halted), 16'h0);
        cyc(1, 16'h8004, 16'h0024, 0, 0, 0);
        cyc(1, 16'h8005, 16'h0026, 0, 0, 0);

        // HALT with fetch error is an ordinary instruction
        cyc(1, 16'h0000, 16'h0028, 1, 0, 0);
        chk("err_halt_errD", 16'(errD), 16'h1);
        cyc(1, 16'h9000, 16'h002A, 0, 0, 0);

        // reset while squashing with one bubble left
        cyc(1, 16'hA000, 16'h002C, 0, 0, 1);
        cyc(0, 16'hA001, 16'h002E, 0, 0, 0);
        chk("rst_mid_squash", 16'(squashing), 16'h0);
        cyc(1, 16'hA002, 16'h0030, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            if ($urandom_range(0, 9) == 0) ri[15:11] = 5'b00000;
            cyc(($urandom_range(0, 49) != 0), ri, 16'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 11) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode_latch.md
Name: fetch_decode_latch

Overview: IF/ID pipeline boundary between the fetch stage and the decode stage. It captures the fetched instruction, incremented PC and fetch error each cycle, and holds them on a stall. On a branch/jump flush it overwrites them with a NOP for a programmable branch-shadow window. It detects HALT entering decode and freezes the front end by deasserting the PC write enable.

Parameters:
NOP_INSTR, 16'h0800, instruction inserted on squash or halt; opcode 00001.
SQUASH_CYCLES, 2, number of consecutive NOP bubbles per flush; legal range 1..7.
HALT_OPCODE, 5'b00000, value of instr[15:11] that marks HALT.

Ports:
clk  input  1  system clock; all state changes on posedge.
rst  input  1  synchronous reset, active-low; sampled on posedge clk.
instrF  input  16  instruction from fetch.
incPCF  input  16  PC+2 from fetch.
errF  input  1  fetch-stage error.
stall  input  1  hazard stall request from the hazard unit.
flush  input  1  branch/jump taken; squash the shadow.
instrD  output  16  instruction presented to decode.
incPCD  output  16  PC+2 presented to decode.
validD  output  1  instrD is a real, non-squashed instruction.
errD  output  1  latched errF, qualified with validD.
pcWrEn  output  1  PC register write enable back to fetch.
halted  output  1  HALT has been captured; front end frozen.
squashing  output  1  state is SQUASH.

Behaviour:
- Reset (rst==0 at posedge):
  - instrD=NOP_INSTR, incPCD=0, validD=0, errD=0.
  - state=RUN, squash counter cnt=0, halted=0.
  - Reset overrides every other input, including mid-squash and halted.
- States: RUN, SQUASH, HALTED. Priority within a cycle: rst > flush > stall > normal load.
- pcWrEn (combinational):
  - 0 when state==HALTED and flush==0.
  - 0 when state==RUN and stall==1 and flush==0.
  - 1 otherwise. A flush always enables the PC write so the redirect lands.
- RUN:
  - flush=1: load instrD=NOP_INSTR, validD=0, errD=0, incPCD held. If SQUASH_CYCLES>1, go to SQUASH with cnt=SQUASH_CYCLES-1; otherwise stay in RUN.
  - Else stall=1: hold instrD, incPCD, validD, errD unchanged.
  - Else: load instrD=instrF, incPCD=incPCF, validD=1, errD=errF. If instrF[15:11]==HALT_OPCODE and errF==0, go to HALTED.
- SQUASH:
  - Each cycle load NOP_INSTR with validD=0 and errD=0. stall is ignored, since a bubble is safe to advance.
  - cnt decrements by 1 each cycle. When cnt==1 at the posedge, the next state is RUN (cnt becomes 0).
  - flush=1 in SQUASH reloads cnt=SQUASH_CYCLES-1; the state stays SQUASH, or goes to RUN if SQUASH_CYCLES==1.
- HALTED:
  - halted=1 (registered; it rises the cycle after HALT is captured, together with the HALT instruction on instrD).
  - The first cycle in HALTED shows HALT on instrD with validD=1. Every following cycle loads NOP_INSTR with validD=0, unless stall=1, in which case all outputs hold.
  - flush=1 means the HALT was on a wrong path: clear halted and take the same action as a flush in RUN.
  - There is no other exit; only reset.
- errD is never 1 while validD==0.
- incPCD is 16 bits with no arithmetic; wrap is the fetch adder's concern.
- Simultaneous flush and stall: flush wins in all states.
- HALT with errF=1 is latched as a normal instruction with errD=1; no halt is taken.

Test Plan:
- Reset/load:
  - Drive rst=0 for 2 cycles -> instrD=16'h0800, incPCD=0, validD=0, pcWrEn=1.
  - Release rst, instrF=16'h4123, incPCF=16'h0002 -> next cycle instrD=16'h4123, incPCD=16'h0002, validD=1.
- Stall hold:
  - In RUN with instrD=16'h4123, assert stall for 3 cycles while instrF changes to 16'hC5AA -> instrD stays 16'h4123 and pcWrEn=0 for all 3 cycles.
  - Release stall -> instrD=16'hC5AA.
- Flush window, SQUASH_CYCLES=2:
  - Pulse flush for 1 cycle -> instrD=16'h0800, validD=0 for exactly 2 cycles, squashing=1 during SQUASH, pcWrEn=1 throughout.
  - The third cycle loads instrF.
  - Re-pulse flush in the second bubble -> the window extends to 3 consecutive bubbles.
- Flush beats stall: assert flush and stall together -> instrD=16'h0800, pcWrEn=1.
- HALT:
  - instrF=16'h0000, errF=0 -> next cycle instrD=16'h0000, validD=1, halted=1, pcWrEn=0.
  - Following cycles instrD=16'h0800, validD=0.
  - flush -> halted=0, pcWrEn=1, SQUASH entered.
- Error and reset mid-operation:
  - instrF=16'h0000 with errF=1 -> errD=1, halted stays 0.
  - Assert rst=0 during SQUASH with cnt=1 -> next cycle state RUN, validD=0, squashing=0.
